// File: rtl/excess3_serial_to_bcd_if.sv
// Handshake bundle for the bit-serial excess-3 decoder: serial input side plus packed BCD output side.
interface excess3_serial_to_bcd_if #(
  parameter int NDIGITS = 4
);
  logic                   in_valid;
  logic                   in_bit;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIGITS-1:0]   bcd_out;
  logic                   err;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, bcd_out, err
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, bcd_out, err
  );
endinterface

// File: rtl/excess3_serial_to_bcd.sv
// Bit-serial excess-3 to packed BCD decoder; each LSB-first nibble has 3 subtracted and
// invalid codes become 4'hF with a sticky per-word error flag.
module excess3_serial_to_bcd #(
  parameter int NDIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sync_clr,
  excess3_serial_to_bcd_if.slave    bus
);
  localparam int WB = 4 * NDIGITS;
  localparam int CW = (WB > 1) ? $clog2(WB) : 1;
  localparam logic [CW-1:0] LAST = CW'(WB - 1);

  typedef enum logic {SHIFT, HOLD} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [3:0]      nib_reg;
  logic [WB-1:0]   word_reg;
  logic            werr_reg;
  logic            out_valid_reg;
  logic [WB-1:0]   bcd_out_reg;
  logic            err_reg;

  logic            in_ready;
  logic            accept;
  logic [3:0]      nib_full;
  logic            nib_done;
  logic            bad;
  logic [3:0]      digit;
  logic            last;
  logic [CW-1:0]   slot_idx;
  logic [WB-1:0]   word_next;

  assign in_ready = (state_reg == SHIFT) || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  // New bit enters at the MSB so the first (LSB) bit ends up in bit 0 after four shifts.
  assign nib_full = {bus.in_bit, nib_reg[3:1]};
  assign nib_done = accept && (cnt_reg[1:0] == 2'b11);
  assign bad      = (nib_full < 4'd3) || (nib_full > 4'd12);
  assign digit    = bad ? 4'hF : (nib_full - 4'd3);
  assign last     = accept && (cnt_reg == LAST);
  assign slot_idx = cnt_reg >> 2;

  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_slot
    assign word_next[4*gi +: 4] = (nib_done && (slot_idx == CW'(gi))) ? digit
                                                                      : word_reg[4*gi +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SHIFT;
      cnt_reg       <= '0;
      nib_reg       <= '0;
      word_reg      <= '0;
      werr_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      bcd_out_reg   <= '0;
      err_reg       <= 1'b0;
    end else if (sync_clr) begin
      state_reg     <= SHIFT;
      cnt_reg       <= '0;
      nib_reg       <= '0;
      word_reg      <= '0;
      werr_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (state_reg == HOLD && bus.out_ready) begin
        out_valid_reg <= 1'b0;
        state_reg     <= SHIFT;
      end
      if (accept) begin
        nib_reg  <= nib_full;
        word_reg <= word_next;
        if (nib_done && bad) begin
          werr_reg <= 1'b1;
        end
        if (last) begin
          // The final digit is folded in directly so the word appears one cycle after its last bit.
          cnt_reg       <= '0;
          werr_reg      <= 1'b0;
          word_reg      <= '0;
          bcd_out_reg   <= word_next;
          err_reg       <= werr_reg || (nib_done && bad);
          out_valid_reg <= 1'b1;
          state_reg     <= HOLD;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.bcd_out   = bcd_out_reg;
  assign bus.err       = err_reg;
endmodule

// File: tb/tb_excess3_serial_to_bcd.sv
// Self-checking bench for excess3_serial_to_bcd: table vectors, corner sequences and a random stream
// checked against a queue-based word model.
module tb_excess3_serial_to_bcd;
  localparam int ND = 4;
  localparam int WB = 4 * ND;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync_clr = 1'b0;

  excess3_serial_to_bcd_if #(.NDIGITS(ND)) bus ();

  excess3_serial_to_bcd #(.NDIGITS(ND)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (sync_clr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic        err;
  } exp_t;

  typedef struct {
    logic [15:0] e3;
    logic [15:0] bcd;
    logic        err;
  } vec_t;

  exp_t        exp_q[$];
  bit          bits_q[$];
  int          rise_q[$];
  bit          ov = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_words = 0;
  bit          got_word;
  logic [15:0] last_word;
  logic        last_err;
  vec_t        vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // One clock: model predicts ready/accept/handshake, then tracks the word stream.
  task automatic tick(output bit acc);
    bit   hs, rdy, cl, b;
    exp_t e;
    #1;
    cl  = sync_clr;
    rdy = !ov || bus.out_ready;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
    hs  = ov && bus.out_ready && !cl;
    acc = bus.in_valid && rdy && !cl;
    b   = bus.in_bit;
    if (hs) begin
      got_word  = 1'b1;
      last_word = bus.bcd_out;
      last_err  = bus.err;
      n_words++;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("bcd_out", {16'd0, bus.bcd_out}, {16'd0, e.word});
        chk("err", {31'd0, bus.err}, {31'd0, e.err});
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (cl) begin
      ov = 1'b0;
      bits_q.delete();
      exp_q.delete();
    end else begin
      if (hs) ov = 1'b0;
      if (acc) begin
        bits_q.push_back(b);
        if (bits_q.size() == WB) begin
          e.word = '0;
          e.err  = 1'b0;
          for (int k = 0; k < ND; k++) begin
            int n;
            n = 0;
            for (int j = 0; j < 4; j++) n += int'(bits_q[4*k+j]) << j;
            if (n >= 3 && n <= 12) begin
              e.word[4*k +: 4] = 4'(n - 3);
            end else begin
              e.word[4*k +: 4] = 4'hF;
              e.err = 1'b1;
            end
          end
          exp_q.push_back(e);
          bits_q.delete();
          rise_q.push_back(cyc);
          ov = 1'b1;
        end
      end
    end
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, ov});
  endtask

  task automatic send_word(input logic [15:0] e3);
    bit a;
    int g;
    for (int i = 0; i < WB; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = e3[i];
      g = 0;
      do begin
        tick(a);
        g++;
      end while (!a && g < 50);
      if (!a) chk("send_timeout", 32'd0, 32'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bits(input int n);
    bit a;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'($urandom_range(0, 1));
      tick(a);
      if (!a) chk("partial_accept", 32'd0, 32'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({nm, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({nm, "_bcd_out"}, {16'd0, bus.bcd_out}, 32'd0);
    chk({nm, "_err"}, {31'd0, bus.err}, 32'd0);
  endtask

  initial begin
    bit a;
    int start, g;

    vt[0] = '{e3: 16'hC654, bcd: 16'h9321, err: 1'b0};
    vt[1] = '{e3: 16'h3033, bcd: 16'h0F00, err: 1'b1};
    vt[2] = '{e3: 16'h3F33, bcd: 16'h0F00, err: 1'b1};
    vt[3] = '{e3: 16'h3333, bcd: 16'h0000, err: 1'b0};
    vt[4] = '{e3: 16'hCCCC, bcd: 16'h9999, err: 1'b0};
    vt[5] = '{e3: 16'h73D2, bcd: 16'h40FF, err: 1'b1};
    vt[6] = '{e3: 16'hB8E1, bcd: 16'h85FF, err: 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Table vectors with the consumer always ready.
    for (int i = 0; i < 7; i++) begin
      got_word = 1'b0;
      send_word(vt[i].e3);
      tick(a);
      chk("vec_got_word", {31'd0, got_word}, 32'd1);
      chk("vec_bcd", {16'd0, last_word}, {16'd0, vt[i].bcd});
      chk("vec_err", {31'd0, last_err}, {31'd0, vt[i].err});
      $display("vec %0d: e3=%h bcd=%h err=%b", i, vt[i].e3, last_word, last_err);
    end

    // Stall: word held while the consumer is not ready and the link keeps offering bits.
    bus.out_ready = 1'b0;
    send_word(vt[0].e3);
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(a);
      chk("stall_bcd_stable", {16'd0, bus.bcd_out}, 32'h0000_9321);
      chk("stall_no_accept", {31'd0, a}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    got_word = 1'b0;
    tick(a);
    chk("stall_release", {31'd0, got_word}, 32'd1);
    got_word = 1'b0;
    send_word(vt[4].e3);
    tick(a);
    chk("after_stall_bcd", {16'd0, last_word}, 32'h0000_9999);
    $display("stall: held 10 cycles, next word bcd=%h", last_word);

    // Back-to-back words with no bubbles.
    rise_q.delete();
    send_word(vt[0].e3);
    send_word(vt[5].e3);
    tick(a);
    chk("b2b_rises", rise_q.size(), 32'd2);
    if (rise_q.size() == 2) chk("b2b_spacing", rise_q[1] - rise_q[0], 32'd16);
    $display("back-to-back: last bcd=%h err=%b", last_word, last_err);

    // Asynchronous reset mid-clock after 7 bits.
    send_bits(7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ov = 1'b0;
    bits_q.delete();
    exp_q.delete();
    got_word = 1'b0;
    send_word(vt[0].e3);
    tick(a);
    chk("post_reset_bcd", {16'd0, last_word}, 32'h0000_9321);
    $display("async reset: following word bcd=%h", last_word);

    // sync_clr after 9 bits, overriding a bit offered in the same cycle.
    send_bits(9);
    sync_clr     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    tick(a);
    sync_clr     = 1'b0;
    bus.in_valid = 1'b0;
    got_word = 1'b0;
    send_word(vt[6].e3);
    tick(a);
    chk("post_clr_bcd", {16'd0, last_word}, 32'h0000_85FF);
    chk("post_clr_err", {31'd0, last_err}, 32'd1);
    $display("sync_clr: following word bcd=%h err=%b", last_word, last_err);

    // Random stream with idle gaps and consumer back-pressure.
    start = n_words;
    g = 0;
    while (n_words - start < 100 && g < 20000) begin
      bus.in_valid  = ($urandom_range(0, 99) >= 30);
      bus.in_bit    = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 99) >= 20);
      tick(a);
      g++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(a);
    chk("random_words", {31'd0, (n_words - start) >= 100}, 32'd1);
    chk("random_drained", exp_q.size(), 32'd0);
    $display("random: %0d words in %0d cycles", n_words - start, g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
